// File: rtl/pipelined_decoder_pkg.sv
// Shared RV32I decode constants: opcodes, one-hot instruction-format codes,
// decoded-field widths and the opcode-to-format lookup.
package pipelined_decoder_pkg;

  localparam logic [6:0] OPC_CAL_R  = 7'b0110011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_CAL_I  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // One-hot instruction format codes
  localparam logic [6:0] OPT_R = 7'b0000001;
  localparam logic [6:0] OPT_I = 7'b0000010;
  localparam logic [6:0] OPT_S = 7'b0000100;
  localparam logic [6:0] OPT_B = 7'b0001000;
  localparam logic [6:0] OPT_U = 7'b0010000;
  localparam logic [6:0] OPT_J = 7'b0100000;
  localparam logic [6:0] OPT_X = 7'b1000000;

  // Decoded bundle bits excluding PC and immediate:
  // funct7 + funct3 + opcode + rs1 + rs2 + rd + op_type + illegal
  localparam int FIELDS_W = 7 + 3 + 7 + 5 + 5 + 5 + 7 + 1;

  function automatic logic [6:0] op_type_of(input logic [6:0] opc);
    logic [6:0] t;
    case (opc)
      OPC_CAL_R:                      t = OPT_R;
      OPC_JALR, OPC_LOAD, OPC_CAL_I:  t = OPT_I;
      OPC_STORE:                      t = OPT_S;
      OPC_BRANCH:                     t = OPT_B;
      OPC_LUI, OPC_AUIPC:             t = OPT_U;
      OPC_JAL:                        t = OPT_J;
      default:                        t = OPT_X;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipelined_decoder_dec_fifo.sv
// Generic synchronous FIFO with synchronous flush. The read side shows the
// head entry while non-empty and holds the last shown value while empty.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready. wr_ready = count < DEPTH and
// rd_valid = count != 0 come from registered state only. flush blocks both
// transfers in its cycle and empties the FIFO at that edge.
module dec_fifo #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             push, pop;

  assign wr_ready = (count_q < CNT_W'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : hold_q;

  // Next-state for storage, pointers (wrap modulo DEPTH), count and hold copy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = rd_data;
    push     = wr_valid && wr_ready && !flush;
    pop      = rd_valid && rd_ready && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= RESET_VAL;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/pipelined_decoder.sv
// Registered, handshaked RV32I instruction decoder. Decodes in_inst
// combinationally, queues the decoded bundle with its PC, and presents the
// head bundle to EX over valid/ready. flush discards everything queued plus
// the instruction offered in the same cycle.
module pipelined_decoder
  import pipelined_decoder_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_inst,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [6:0]            funct7,
  output logic [2:0]            funct3,
  output logic [6:0]            opcode,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [6:0]            OP_type,
  output logic                  illegal
);

  localparam int BUNDLE_W = ADDR_WIDTH + DATA_WIDTH + FIELDS_W;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [6:0]            opcode;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] imm;
    logic [6:0]            op_type;
    logic                  illegal;
  } bundle_t;

  // Reset bundle: every field zero except op_type = X (bits [7:1])
  localparam logic [BUNDLE_W-1:0] RESET_BUNDLE = {{(BUNDLE_W-8){1'b0}}, OPT_X, 1'b0};

  bundle_t     dec_b;
  bundle_t     head;
  logic [31:0] inst;
  logic [31:0] imm32;
  logic [6:0]  raw_type;
  logic        bad;

  assign inst = in_inst[31:0];

  // Combinational decode of the offered instruction into a bundle
  always_comb begin
    dec_b        = '0;
    dec_b.pc     = in_pc;
    dec_b.funct7 = inst[31:25];
    dec_b.funct3 = inst[14:12];
    dec_b.opcode = inst[6:0];
    dec_b.rs1    = inst[19:15];
    dec_b.rs2    = inst[24:20];
    dec_b.rd     = inst[11:7];
    raw_type     = op_type_of(inst[6:0]);
    bad = (inst[1:0] != 2'b11) || (raw_type == OPT_X)
       || ((inst[6:0] == OPC_JALR)   && (inst[14:12] != 3'd0))
       || ((inst[6:0] == OPC_LOAD)   && ((inst[14:12] == 3'd3) || (inst[14:12] >= 3'd6)))
       || ((inst[6:0] == OPC_STORE)  && (inst[14:12] > 3'd2))
       || ((inst[6:0] == OPC_BRANCH) && ((inst[14:12] == 3'd2) || (inst[14:12] == 3'd3)))
       || ((inst[6:0] == OPC_CAL_R)  && (inst[31:25] != 7'h00) && (inst[31:25] != 7'h20))
       || ((inst[6:0] == OPC_CAL_R)  && (inst[31:25] == 7'h20)
           && (inst[14:12] != 3'd0) && (inst[14:12] != 3'd5));
    // Illegal encodings travel as format X with a zero immediate
    dec_b.illegal = bad;
    dec_b.op_type = bad ? OPT_X : raw_type;
    case (dec_b.op_type)
      OPT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      OPT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPT_U:   imm32 = {inst[31:12], 12'b0};
      OPT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
    dec_b.imm = DATA_WIDTH'($signed(imm32));
  end

  dec_fifo #(
    .WIDTH     (BUNDLE_W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_BUNDLE)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (dec_b),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (head)
  );

  assign out_pc  = head.pc;
  assign funct7  = head.funct7;
  assign funct3  = head.funct3;
  assign opcode  = head.opcode;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign rd      = head.rd;
  assign imm     = head.imm;
  assign OP_type = head.op_type;
  assign illegal = head.illegal;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Directed bench for pipelined_decoder: reset state, field decode for each
// instruction format, backpressure/drain order, flush and async reset.
module tb_pipelined_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [6:0]  OP_type;
  logic        illegal;

  int tests_run;
  int tests_failed;

  pipelined_decoder #(
    .INST_WIDTH (32),
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .funct7    (funct7),
    .funct3    (funct3),
    .opcode    (opcode),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .OP_type   (OP_type),
    .illegal   (illegal)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_handshake: got valid/ready=%b required 01", {out_valid, in_ready});
    end
    tests_run++;
    if ({out_pc, imm, OP_type, illegal, rd} !== {32'h0, 32'h0, 7'h40, 1'b0, 5'h0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got pc=%h imm=%h type=%h ill=%b rd=%0d required pc=0 imm=0 type=40 ill=0 rd=0",
               out_pc, imm, OP_type, illegal, rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] v_inst [9];
    logic [103:0] v_exp [9];
    logic [103:0] got;
    // expected: {rd, rs1, rs2, funct3, funct7, opcode, imm, OP_type, illegal, out_pc}
    v_inst[0] = 32'h00500093; v_exp[0] = {5'd1,  5'd0, 5'd5, 3'd0, 7'h00, 7'h13, 32'h00000005, 7'h02, 1'b0, 32'h100};
    v_inst[1] = 32'hFE20AE23; v_exp[1] = {5'h1C, 5'd1, 5'd2, 3'd2, 7'h7F, 7'h23, 32'hFFFFFFFC, 7'h04, 1'b0, 32'h104};
    v_inst[2] = 32'h123452B7; v_exp[2] = {5'd5,  5'd8, 5'd3, 3'd5, 7'h09, 7'h37, 32'h12345000, 7'h10, 1'b0, 32'h108};
    v_inst[3] = 32'h00000000; v_exp[3] = {5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 7'h00, 32'h00000000, 7'h40, 1'b1, 32'h10C};
    v_inst[4] = 32'h0000F067; v_exp[4] = {5'd0,  5'd1, 5'd0, 3'd7, 7'h00, 7'h67, 32'h00000000, 7'h40, 1'b1, 32'h110};
    v_inst[5] = 32'h002081B3; v_exp[5] = {5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 7'h33, 32'h00000000, 7'h01, 1'b0, 32'h114};
    v_inst[6] = 32'h008000EF; v_exp[6] = {5'd1,  5'd0, 5'd8, 3'd0, 7'h00, 7'h6F, 32'h00000008, 7'h20, 1'b0, 32'h118};
    v_inst[7] = 32'hFE208CE3; v_exp[7] = {5'h19, 5'd1, 5'd2, 3'd0, 7'h7F, 7'h63, 32'hFFFFFFF8, 7'h08, 1'b0, 32'h11C};
    v_inst[8] = 32'h401091B3; v_exp[8] = {5'd3,  5'd1, 5'd1, 3'd1, 7'h20, 7'h33, 32'h00000000, 7'h40, 1'b1, 32'h120};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_inst  = v_inst[i];
      in_pc    = 32'h100 + 32'(4 * i);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL decode_valid[%0d]: got out_valid=%b required 1", i, out_valid);
      end
      got = {rd, rs1, rs2, funct3, funct7, opcode, imm, OP_type, illegal, out_pc};
      tests_run++;
      if (got !== v_exp[i]) begin
        tests_failed++;
        $display("FAIL decode_fields[%0d] inst=%h: got %h required %h", i, v_inst[i], got, v_exp[i]);
      end
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL decode_drained: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00100093;
    in_pc     = 32'h200;
    @(posedge clk); #1;
    tests_run++;
    if ({in_ready, out_valid, out_pc} !== {1'b1, 1'b1, 32'h200}) begin
      tests_failed++;
      $display("FAIL bp_one: got ready=%b valid=%b pc=%h required 1 1 00000200", in_ready, out_valid, out_pc);
    end
    in_inst = 32'h00200093; in_pc = 32'h204;
    @(posedge clk); #1;
    tests_run++;
    if ({in_ready, out_pc} !== {1'b0, 32'h200}) begin
      tests_failed++;
      $display("FAIL bp_full: got ready=%b pc=%h required 0 00000200", in_ready, out_pc);
    end
    in_inst = 32'h00300093; in_pc = 32'h208;
    @(posedge clk); #1;
    tests_run++;
    if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 32'h200}) begin
      tests_failed++;
      $display("FAIL bp_held: got ready=%b valid=%b pc=%h required 0 1 00000200", in_ready, out_valid, out_pc);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({in_ready, out_valid, out_pc, rd} !== {1'b1, 1'b1, 32'h204, 5'd1}) begin
      tests_failed++;
      $display("FAIL bp_drain_b: got ready=%b valid=%b pc=%h rd=%0d required 1 1 00000204 1",
               in_ready, out_valid, out_pc, rd);
    end
    // push of the third instruction and pop of the second share this edge
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, out_pc, imm} !== {1'b1, 1'b1, 32'h208, 32'd3}) begin
      tests_failed++;
      $display("FAIL bp_push_pop: got ready=%b valid=%b pc=%h imm=%h required 1 1 00000208 00000003",
               in_ready, out_valid, out_pc, imm);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, in_ready, out_pc, imm} !== {1'b0, 1'b1, 32'h208, 32'd3}) begin
      tests_failed++;
      $display("FAIL bp_empty_hold: got valid=%b ready=%b pc=%h imm=%h required 0 1 00000208 00000003",
               out_valid, in_ready, out_pc, imm);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00400093; in_pc = 32'h300;
    @(posedge clk); #1;
    in_inst   = 32'h00500093; in_pc = 32'h304;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL flush_prefill: got valid/ready=%b required 10", {out_valid, in_ready});
    end
    in_inst = 32'h00600093; in_pc = 32'h308;
    flush   = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_clear: got valid/ready=%b required 01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_dropped: got out_valid=%b pc=%h required 0", out_valid, out_pc);
    end
    in_valid = 1'b1; in_inst = 32'h00700093; in_pc = 32'h30C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_pc, imm} !== {1'b1, 32'h30C, 32'd7}) begin
      tests_failed++;
      $display("FAIL flush_next: got valid=%b pc=%h imm=%h required 1 0000030c 00000007", out_valid, out_pc, imm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_inst = 32'h00800093; in_pc = 32'h400;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_prefill: got out_valid=%b required 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, out_pc, OP_type, imm} !== {1'b0, 1'b1, 32'h0, 7'h40, 32'h0}) begin
      tests_failed++;
      $display("FAIL arst_immediate: got valid=%b ready=%b pc=%h type=%h imm=%h required 0 1 0 40 0",
               out_valid, in_ready, out_pc, OP_type, imm);
    end
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1; in_inst = 32'h00500093; in_pc = 32'h500;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, rd, rs1, imm, OP_type, illegal, out_pc} !==
        {1'b1, 5'd1, 5'd0, 32'd5, 7'h02, 1'b0, 32'h500}) begin
      tests_failed++;
      $display("FAIL arst_first_push: got valid=%b rd=%0d rs1=%0d imm=%h type=%h ill=%b pc=%h required 1 1 0 5 02 0 500",
               out_valid, rd, rs1, imm, OP_type, illegal, out_pc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
